btn_irq_arbiter: RTL

BTN_IRQ_ARBITER -- requirements
Module: btn_irq_arbiter

---
 rtl/btn_irq_pkg.sv | 14 +
 rtl/btn_rr_select.sv | 46 ++++
 rtl/btn_irq_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/btn_irq_pkg.sv
// btn_irq_pkg -- shared definitions for the button interrupt arbiter.
//   N_SRC_DEFAULT : default number of debounced button sources
//   btn_state_t   : arbiter FSM state (IDLE waits for pending work,
//                   PRESENT holds an event until the consumer accepts it)
package btn_irq_pkg;

  localparam int unsigned N_SRC_DEFAULT = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } btn_state_t;

endpackage

// File: rtl/btn_rr_select.sv
// btn_rr_select -- combinational winner selection.
// Scans the request vector starting at index 'start', wrapping modulo
// N_SRC, and returns the first requesting index.
//   req    : request vector, one bit per source
//   start  : index where the search begins (0 gives fixed priority)
//   winner : selected index (0 when no request is set)
//   any    : at least one request is set
module btn_rr_select
  import btn_irq_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEFAULT
) (
  input  logic [N_SRC-1:0]         req,
  input  logic [$clog2(N_SRC)-1:0] start,
  output logic [$clog2(N_SRC)-1:0] winner,
  output logic                     any
);

  localparam int unsigned ID_W = $clog2(N_SRC);

  logic [2*N_SRC-1:0] rot2;
  logic [N_SRC-1:0]   rot;
  logic               found;
  int unsigned        pos;

  // Doubling the vector makes the wrap-around a plain right shift:
  // rot[k] is the request at index (start + k) mod N_SRC.
  assign rot2 = {req, req} >> start;
  assign rot  = rot2[N_SRC-1:0];
  assign any  = |req;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    pos    = 0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = 32'(start) + k;
        if (pos >= N_SRC) pos = pos - N_SRC;
        winner = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/btn_irq_arbiter.sv
// btn_irq_arbiter -- collects one-cycle button press pulses into pending
// flags and presents them one at a time over a valid/ready handshake,
// with a level interrupt mirroring evt_valid.
// Configuration macro: BTN_IRQ_RR_EN -- when defined, the winner is chosen
// round-robin after the last grant; otherwise lowest index wins and no
// last-grant register exists.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   src_pls    : one-cycle press pulses, one bit per source
//   src_mask   : 1 = source enabled; disabling also clears its pending flag
//   evt_valid  : an event is presented on evt_id
//   evt_id     : index of the presented source
//   evt_ready  : consumer accepts the event when high with evt_valid
//   irq        : level interrupt, equal to evt_valid
//   pending    : presses captured but not yet presented
//   overflow   : sticky, a press arrived while its source was still pending
//   ovf_clr    : clears overflow (a new overflow on the same edge still sets)
module btn_irq_arbiter
  import btn_irq_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_SRC-1:0]         src_pls,
  input  logic [N_SRC-1:0]         src_mask,
  output logic                     evt_valid,
  output logic [$clog2(N_SRC)-1:0] evt_id,
  input  logic                     evt_ready,
  output logic                     irq,
  output logic [N_SRC-1:0]         pending,
  output logic [N_SRC-1:0]         overflow,
  input  logic                     ovf_clr
);

  localparam int unsigned ID_W = $clog2(N_SRC);

  btn_state_t       state;
  logic [ID_W-1:0]  start;
  logic [ID_W-1:0]  winner;
  logic             any_pending;
  logic             grant;
  logic [N_SRC-1:0] grant_vec;
  logic [N_SRC-1:0] armed;
  logic [N_SRC-1:0] ovf_set;
  logic [N_SRC-1:0] pending_nxt;

  btn_rr_select #(
    .N_SRC (N_SRC)
  ) u_select (
    .req    (pending),
    .start  (start),
    .winner (winner),
    .any    (any_pending)
  );

`ifdef BTN_IRQ_RR_EN
  logic [ID_W-1:0] last_grant;

  assign start = (last_grant == ID_W'(N_SRC - 1)) ? '0 : last_grant + ID_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(N_SRC - 1);
    end else if (grant) begin
      last_grant <= winner;
    end
  end
`else
  assign start = '0;
`endif

  assign grant = (state == ST_IDLE) && any_pending;

  // A press on the source being granted re-arms it (set wins) and is not
  // an overflow, since the earlier press is leaving pending on this edge.
  always_comb begin
    grant_vec   = grant ? ({{(N_SRC-1){1'b0}}, 1'b1} << winner) : '0;
    armed       = src_pls & src_mask;
    ovf_set     = armed & pending & ~grant_vec;
    pending_nxt = src_mask & (armed | (pending & ~grant_vec));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      pending   <= '0;
      overflow  <= '0;
    end else begin
      pending  <= pending_nxt;
      overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state     <= ST_PRESENT;
            evt_valid <= 1'b1;
            evt_id    <= winner;
          end
        end
        ST_PRESENT: begin
          if (evt_ready) begin
            state     <= ST_IDLE;
            evt_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

  assign irq = evt_valid;

endmodule
